fp_mul_unit: RTL and testbench
==============================

FP_MUL_UNIT -- requirements
Module: fp_mul_unit

Interface
REQ-001 SHALL have parameter CANON_NAN, default 32'h7FC00000, the quiet NaN returned for every invalid or NaN result.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port opA  input  32  IEEE-754 single operand (from FP register file readData1).
REQ-006 SHALL have port opB  input  32  IEEE-754 single operand (from FP register file readData2).
REQ-007 SHALL have port rd  input  5  destination FP register index.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port regWrite  output  1  one-cycle write strobe to the FP register file.
REQ-010 SHALL have port writeRegister  output  5  captured rd, valid while regWrite is high.
REQ-011 SHALL have port writeData  output  32  product, valid while regWrite is high.

Function
REQ-012 SHALL implement states IDLE, CHECK, MUL, NORM, WB.
REQ-013 In IDLE with start=1 it SHALL capture opA, opB and rd, then enter CHECK on the same edge.
REQ-014 While busy, start SHALL be ignored, and the captured operands and rd SHALL NOT change.
REQ-015 In CHECK it SHALL unpack both operands and flush subnormal inputs to signed zero.
REQ-016 CHECK SHALL go directly to WB on any special case.
  - Special cases: NaN operand, inf*0, inf*x, 0*x.
  - Otherwise CHECK SHALL go to MUL.
REQ-017 MUL SHALL form the 48-bit product of the two 24-bit significands (hidden bit included) by iterative shift-add.
  - One multiplier bit per cycle, exactly 24 cycles, using a 5-bit step counter that runs 0..23.
REQ-018 Exponent SHALL be computed in 10-bit signed arithmetic as eA+eB-127, plus 1 when product bit 47 is set.
  - The product SHALL be normalised so the hidden bit sits at bit 23.
REQ-019 NORM SHALL round to nearest, ties to even.
  - Guard bit = the bit below the result LSB; sticky = OR of all lower bits.
  - A rounding carry out of the significand SHALL renormalise the result and increment the exponent.
REQ-020 A final exponent >= 255 SHALL yield signed infinity.
REQ-021 A final exponent <= 0 SHALL yield signed zero; no subnormal outputs are produced.
REQ-022 Result sign SHALL be signA XOR signB for every non-NaN result.
REQ-023 Special-case results:
  - NaN operand or inf*0: CANON_NAN.
  - inf*finite-nonzero or inf*inf: signed inf.
  - zero*finite: signed zero.
REQ-024 In WB, regWrite SHALL be 1 for exactly one cycle, with writeRegister and writeData valid in that cycle.
  - WB SHALL return to IDLE on the next edge.
REQ-025 Latency from the start-sampling edge to the WB cycle:
  - Normal path: WB is entered on the 26th following edge (CHECK 1 + MUL 24 + NORM 1).
  - Special path: WB is entered on the 1st following edge.
REQ-026 busy SHALL fall on the edge leaving WB, so a new start is accepted in the cycle after WB.
REQ-027 Outside WB, regWrite SHALL be 0, and writeData/writeRegister SHALL hold their last values.
REQ-028 rd=0 SHALL be processed normally; discarding the write is the register file's concern.

Reset
REQ-029 On reset assertion, regardless of clk, the block SHALL take these values:
  - state = IDLE, busy = 0, regWrite = 0.
  - writeRegister = 0, writeData = 0.
  - step counter = 0, internal datapath registers = 0.
REQ-030 Reset mid-operation SHALL abort the operation with no regWrite pulse.
  - The first start after reset deassertion SHALL be accepted normally.

Structure
REQ-031 A shared package riscv_fp_pkg SHALL hold the following:
  - FSM state encoding.
  - Constants: FP_BIAS=127, FP_EXP_MAX=255, FP_CANON_NAN, FP_POS_INF=32'h7F800000, FP_MUL_STEPS=24.
REQ-032 Normalise/round logic SHALL be one combinational sub-module, fp_round_norm.
  - Inputs: sign, 10-bit exponent, 48-bit product.
  - Output: 32-bit packed result.
  - The FSM, counter and shift-add datapath stay in fp_mul_unit.

Verification
REQ-033 Bench SHALL cover the normal-path latency and a positive result.
  - Stimulus: opA=0x40000000, opB=0x40400000, rd=5, start for 1 cycle.
  - Required: regWrite high exactly 26 edges later, writeRegister=5, writeData=0x40C00000.
REQ-034 Bench SHALL cover a negative result.
  - Stimulus: opA=0x3FC00000, opB=0xC0000000.
  - Required: writeData=0xC0400000; busy high from the start edge until the edge after WB.
REQ-035 Bench SHALL cover the special-case fast path.
  - Stimulus: opA=0x7F800000, opB=0x00000000.
  - Required: writeData=0x7FC00000, regWrite 1 edge after start.
REQ-036 Bench SHALL cover overflow and underflow.
  - Overflow: opA=opB=0x7F000000 -> writeData=0x7F800000.
  - Underflow: opA=opB=0x00800000 -> writeData=0x00000000.
REQ-037 Bench SHALL cover rounding.
  - Stimulus: opA=opB=0x3F800001.
  - Required: writeData=0x3F800002 (sticky set, guard clear, round down).
REQ-038 Bench SHALL cover start-while-busy and reset mid-operation.
  - Start-while-busy: a second start 10 cycles into an operation is ignored, and only the first result is written.
  - Reset mid-operation: reset asserted in MUL gives busy=0 and regWrite=0 immediately, and no write follows.

Source files
------------

// File: rtl/riscv_fp_pkg.sv
// Shared single-precision FP definitions: multiplier FSM encoding and IEEE-754 constants.
package riscv_fp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MUL   = 3'd2,
        NORM  = 3'd3,
        WB    = 3'd4
    } fpMulState_t;

    localparam int          FP_BIAS      = 127;
    localparam int          FP_EXP_MAX   = 255;
    localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;
    localparam logic [31:0] FP_POS_INF   = 32'h7F800000;
    localparam int          FP_MUL_STEPS = 24;

endpackage

// File: rtl/fp_round_norm.sv
// Normalises a 48-bit significand product, rounds to nearest-even and packs an
// IEEE-754 single result, saturating to signed infinity or flushing to signed zero.
module fp_round_norm
    import riscv_fp_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exponent,
    input  logic [47:0]       product,
    output logic [31:0]       result
);

    logic [23:0]       mant;
    logic              guard;
    logic              sticky;
    logic              roundUp;
    logic [24:0]       rounded;
    logic [22:0]       fracFinal;
    logic signed [9:0] expAdj;
    logic signed [9:0] expFinal;

    always_comb begin
        mant      = 24'd0;
        guard     = 1'b0;
        sticky    = 1'b0;
        expAdj    = exponent;
        fracFinal = 23'd0;
        expFinal  = exponent;
        result    = 32'd0;

        // Normal operands give a product in [2^46, 2^48), so the MSB is bit 47 or 46.
        if (product[47]) begin
            mant   = product[47:24];
            guard  = product[23];
            sticky = |product[22:0];
            expAdj = exponent + 10'sd1;
        end else begin
            mant   = product[46:23];
            guard  = product[22];
            sticky = |product[21:0];
            expAdj = exponent;
        end

        roundUp = guard & (sticky | mant[0]);
        rounded = {1'b0, mant} + {24'd0, roundUp};

        // A carry out leaves 1.000..0 x 2, so the fraction is all zeros.
        if (rounded[24]) begin
            fracFinal = rounded[23:1];
            expFinal  = expAdj + 10'sd1;
        end else begin
            fracFinal = rounded[22:0];
            expFinal  = expAdj;
        end

        if (expFinal >= $signed(10'(FP_EXP_MAX))) begin
            result = {sign, FP_POS_INF[30:0]};
        end else if (expFinal <= 10'sd0) begin
            result = {sign, 31'd0};
        end else begin
            result = {sign, expFinal[7:0], fracFinal};
        end
    end

endmodule

// File: rtl/fp_mul_unit.sv
// Multi-cycle IEEE-754 single-precision multiplier: captures operands on start,
// resolves special cases in one cycle, otherwise shift-add multiplies and rounds.
module fp_mul_unit
    import riscv_fp_pkg::*;
#(
    parameter logic [31:0] CANON_NAN = FP_CANON_NAN
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        regWrite,
    output logic [4:0]  writeRegister,
    output logic [31:0] writeData
);

    localparam logic [4:0] LAST_STEP = 5'(FP_MUL_STEPS - 1);

    fpMulState_t       state;
    fpMulState_t       nextState;

    logic [31:0]       capA;
    logic [31:0]       capB;
    logic [4:0]        capRd;
    logic [47:0]       mcand;
    logic [47:0]       prod;
    logic [23:0]       mplier;
    logic [4:0]        step;
    logic signed [9:0] expSum;

    logic              signRes;
    logic [7:0]        expA;
    logic [7:0]        expB;
    logic [22:0]       fracA;
    logic [22:0]       fracB;
    logic              zeroA;
    logic              zeroB;
    logic              infA;
    logic              infB;
    logic              nanA;
    logic              nanB;
    logic              isSpecial;
    logic [31:0]       specialRes;
    logic signed [9:0] expCalc;
    logic [31:0]       normResult;

    // Operand classification; a zero exponent field (zero or subnormal) counts as zero.
    assign signRes = capA[31] ^ capB[31];
    assign expA    = capA[30:23];
    assign expB    = capB[30:23];
    assign fracA   = capA[22:0];
    assign fracB   = capB[22:0];
    assign zeroA   = (expA == 8'd0);
    assign zeroB   = (expB == 8'd0);
    assign infA    = (expA == 8'hFF) && (fracA == 23'd0);
    assign infB    = (expB == 8'hFF) && (fracB == 23'd0);
    assign nanA    = (expA == 8'hFF) && (fracA != 23'd0);
    assign nanB    = (expB == 8'hFF) && (fracB != 23'd0);

    assign isSpecial = zeroA | zeroB | infA | infB | nanA | nanB;
    assign expCalc   = $signed({2'b00, expA}) + $signed({2'b00, expB})
                     - $signed(10'(FP_BIAS));

    always_comb begin
        specialRes = {signRes, 31'd0};
        if (nanA || nanB || (infA && zeroB) || (infB && zeroA)) begin
            specialRes = CANON_NAN;
        end else if (infA || infB) begin
            specialRes = {signRes, FP_POS_INF[30:0]};
        end
    end

    fp_round_norm uRoundNorm (
        .sign     (signRes),
        .exponent (expSum),
        .product  (prod),
        .result   (normResult)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = CHECK;
            CHECK:   nextState = isSpecial ? WB : MUL;
            MUL:     if (step == LAST_STEP) nextState = NORM;
            NORM:    nextState = WB;
            WB:      nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            capA          <= 32'd0;
            capB          <= 32'd0;
            capRd         <= 5'd0;
            mcand         <= 48'd0;
            prod          <= 48'd0;
            mplier        <= 24'd0;
            step          <= 5'd0;
            expSum        <= 10'sd0;
            writeRegister <= 5'd0;
            writeData     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        capA  <= opA;
                        capB  <= opB;
                        capRd <= rd;
                    end
                end
                CHECK: begin
                    if (isSpecial) begin
                        writeData     <= specialRes;
                        writeRegister <= capRd;
                    end else begin
                        mcand  <= {24'd0, 1'b1, fracA};
                        mplier <= {1'b1, fracB};
                        prod   <= 48'd0;
                        step   <= 5'd0;
                        expSum <= expCalc;
                    end
                end
                MUL: begin
                    // One multiplier bit per cycle, LSB first, multiplicand shifted to match.
                    if (mplier[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    step   <= (step == LAST_STEP) ? 5'd0 : step + 5'd1;
                end
                NORM: begin
                    writeData     <= normResult;
                    writeRegister <= capRd;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign regWrite = (state == WB);

endmodule

// File: tb/tb_fp_mul_unit.sv
// Self-checking bench for fp_mul_unit: directed corner cases plus random operands,
// scored against an arithmetic reference model through an expected-result queue.
module tb_fp_mul_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] opA = 32'd0;
    logic [31:0] opB = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        busy;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;

    int errors = 0;
    int checks = 0;
    logic [36:0] exp_q[$];

    fp_mul_unit #(.CANON_NAN(32'h7FC00000)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .opA           (opA),
        .opB           (opB),
        .rd            (rd),
        .busy          (busy),
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .writeData     (writeData)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Reference model: exact integer product, round-half-even on the remainder.
    function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, sh;
        longint unsigned fa, fb, p, q, rem, half;
        bit aNan, bNan, aInf, bInf, aZero, bZero;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = longint'(a[22:0]);
        fb = longint'(b[22:0]);
        aNan = (ea == 255) && (fa != 0);
        bNan = (eb == 255) && (fb != 0);
        aInf = (ea == 255) && (fa == 0);
        bInf = (eb == 255) && (fb == 0);
        aZero = (ea == 0);
        bZero = (eb == 0);
        if (aNan || bNan) return 32'h7FC00000;
        if ((aInf && bZero) || (bInf && aZero)) return 32'h7FC00000;
        if (aInf || bInf) return {s, 8'hFF, 23'd0};
        if (aZero || bZero) return {s, 31'd0};
        p  = ((64'd1 << 23) + fa) * ((64'd1 << 23) + fb);
        sh = (p >= (64'd1 << 47)) ? 24 : 23;
        e  = ea + eb - 127 + ((sh == 24) ? 1 : 0);
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), q[22:0]};
    endfunction

    function automatic bit isSpecialOp(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
               (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
    endfunction

    function automatic logic [31:0] randOp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: v[30:23] = 8'h00;
            1: begin
                v[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 0) v[22:0] = 23'd0;
            end
            2: v[30:23] = 8'($urandom_range(200, 254));
            3: v[30:23] = 8'($urandom_range(1, 60));
            4: begin
                v[30:23] = 8'($urandom_range(100, 150));
                v[22:0]  = 23'(1 << $urandom_range(0, 22));
            end
            default: v[30:23] = 8'($urandom_range(64, 190));
        endcase
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Monitor / scoreboard: every write strobe must match the oldest expectation.
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (!reset && regWrite) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got rd=%0d data=%h, required no write",
                             writeRegister, writeData);
                end else begin
                    e = exp_q.pop_front();
                    if ({writeRegister, writeData} !== e) begin
                        errors++;
                        $display("FAIL write_result: got rd=%0d data=%h, required rd=%0d data=%h",
                                 writeRegister, writeData, e[36:32], e[31:0]);
                    end
                end
            end
        end
    end

    // Driver: one operation with latency and busy-window checks.
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                         input logic [31:0] want, input bit useWant);
        int lat;
        bit seen;
        bit busyGap;
        @(negedge clk);
        opA = a;
        opB = b;
        rd = r;
        start = 1'b1;
        exp_q.push_back({r, useWant ? want : refMul(a, b)});
        @(posedge clk);
        #1 start = 1'b0;
        checkVal("busy_after_start", {31'd0, busy}, 32'd1);
        seen = 1'b0;
        busyGap = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (regWrite) begin
                seen = 1'b1;
                lat = n;
            end else if (!busy) begin
                busyGap = 1'b1;
            end
        end
        checkVal("write_seen", {31'd0, seen}, 32'd1);
        checkVal("busy_held", {31'd0, busyGap}, 32'd0);
        checkVal("latency", lat, isSpecialOp(a, b) ? 32'd1 : 32'd26);
        checkVal("busy_in_wb", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        checkVal("busy_after_wb", {31'd0, busy}, 32'd0);
        checkVal("regwrite_after_wb", {31'd0, regWrite}, 32'd0);
    endtask

    initial begin
        int lat;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkVal("reset_busy", {31'd0, busy}, 32'd0);
        checkVal("reset_regwrite", {31'd0, regWrite}, 32'd0);
        checkVal("reset_wdata", writeData, 32'd0);
        checkVal("reset_wreg", {27'd0, writeRegister}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases
        runOp(32'h40000000, 32'h40400000, 5'd5,  32'h40C00000, 1'b1);
        runOp(32'h3FC00000, 32'hC0000000, 5'd7,  32'hC0400000, 1'b1);
        runOp(32'h7F800000, 32'h00000000, 5'd3,  32'h7FC00000, 1'b1);
        runOp(32'h7F000000, 32'h7F000000, 5'd11, 32'h7F800000, 1'b1);
        runOp(32'h00800000, 32'h00800000, 5'd12, 32'h00000000, 1'b1);
        runOp(32'h3F800001, 32'h3F800001, 5'd13, 32'h3F800002, 1'b1);
        runOp(32'h3F800000, 32'h3F800000, 5'd0,  32'h3F800000, 1'b1);
        runOp(32'h7FC12345, 32'h3F800000, 5'd14, 32'h7FC00000, 1'b1);
        runOp(32'h7F800000, 32'hC0000000, 5'd15, 32'hFF800000, 1'b1);
        runOp(32'h00400000, 32'hC0000000, 5'd16, 32'h80000000, 1'b1);
        runOp(32'h3FFFFFFF, 32'h3FFFFFFF, 5'd17, 32'h407FFFFE, 1'b1);

        // Start while busy: second request 10 edges in must be ignored
        @(negedge clk);
        opA = 32'h40000000;
        opB = 32'h40400000;
        rd = 5'd9;
        start = 1'b1;
        exp_q.push_back({5'd9, 32'h40C00000});
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        opA = 32'h3F800000;
        opB = 32'h3F800000;
        rd = 5'd12;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int n = 11; n <= 50 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (regWrite) lat = n;
        end
        checkVal("busy_start_latency", lat, 32'd26);
        repeat (40) @(posedge clk);
        #1;
        checkVal("busy_start_queue", exp_q.size(), 32'd0);

        // Reset in the middle of MUL aborts without a write
        @(negedge clk);
        opA = 32'h40000000;
        opB = 32'h40000000;
        rd = 5'd21;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checkVal("midreset_busy", {31'd0, busy}, 32'd0);
        checkVal("midreset_regwrite", {31'd0, regWrite}, 32'd0);
        checkVal("midreset_wdata", writeData, 32'd0);
        checkVal("midreset_wreg", {27'd0, writeRegister}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        runOp(32'h40400000, 32'h40400000, 5'd22, 32'h41100000, 1'b1);

        // Random operands against the model
        for (int i = 0; i < 60; i++) begin
            runOp(randOp(), randOp(), 5'($urandom_range(0, 31)), 32'd0, 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        checkVal("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
